// File: rtl/merge_sort_pkg.sv
// Shared definitions for the merge-sort slice: pass-scheduler state encoding,
// default register-file address width and a constant log2 helper. Imported by
// the controller, the merge unit and the register file.
package merge_sort_pkg;

  // Pass-scheduler states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MERGE  = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Default register-file address width (holds up to 32 words)
  localparam int unsigned MS_ADDR_W = 32'd5;

  // Ceiling log2 for elaboration-time constants
  function automatic int unsigned ms_clog2(input int unsigned value);
    int unsigned res;
    res = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 32'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/merge_addr_gen.sv
// Address generator for the merge-sort pass scheduler. Owns the run length,
// pair base and the load/write counters, and produces registered read and
// write addresses that are already valid in the cycle the FSM acts on them.
// Optional build macro: MERGE_CTRL_TIMEOUT_EN exposes run_len to the watchdog.
module merge_addr_gen
  import merge_sort_pkg::*;
#(
  parameter int unsigned N      = 32'd8,
  parameter int unsigned ADDR_W = MS_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,       // sort starts: clear all counters
  input  logic              ld_step,    // one FIFO push happens this cycle
  input  logic              sel_b_nxt,  // next cycle reads the second run
  input  logic              wr_step,    // merge unit writes this cycle
  input  logic              next_pair,  // advance to the next pair of runs
`ifdef MERGE_CTRL_TIMEOUT_EN
  output logic [ADDR_W:0]   run_len,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ld_last,    // this push completes a run
  output logic              wr_last,    // this write completes the pair
  output logic              pass_wrap,  // this pair is the last of its pass
  output logic              sort_last   // this pair is the last of the sort
);

  localparam int unsigned CW  = ADDR_W + 32'd1;
  localparam logic [CW-1:0] N_C = CW'(N);

  logic [CW-1:0] pair_base_r, run_len_r, ld_cnt_r, wr_cnt_r;
  logic [CW-1:0] pair_base_s, run_len_s, ld_cnt_s, wr_cnt_s;
  logic [CW-1:0] twice_rl_s, pb_sum_s, rd_off_s;
  logic [ADDR_W-1:0] rd_addr_r, wr_addr_r;

  // Status flags derived from the current counter values
  always_comb begin
    twice_rl_s = {run_len_r[CW-2:0], 1'b0};
    pb_sum_s   = pair_base_r + twice_rl_s;
    ld_last    = (ld_cnt_r == (run_len_r - CW'(1)));
    wr_last    = (wr_cnt_r == (twice_rl_s - CW'(1)));
    pass_wrap  = (pb_sum_s == N_C);
    sort_last  = pass_wrap && (twice_rl_s == N_C);
  end

  // Next counter values from the FSM strobes
  always_comb begin
    pair_base_s = pair_base_r;
    run_len_s   = run_len_r;
    ld_cnt_s    = ld_cnt_r;
    wr_cnt_s    = wr_cnt_r;
    if (init) begin
      pair_base_s = '0;
      run_len_s   = CW'(1);
      ld_cnt_s    = '0;
      wr_cnt_s    = '0;
    end else begin
      if (ld_step) begin
        ld_cnt_s = ld_last ? '0 : (ld_cnt_r + CW'(1));
      end else begin
        ld_cnt_s = ld_cnt_r;
      end
      if (wr_step) begin
        wr_cnt_s = wr_cnt_r + CW'(1);
      end else if (next_pair) begin
        wr_cnt_s = '0;
      end else begin
        wr_cnt_s = wr_cnt_r;
      end
      if (next_pair && pass_wrap) begin
        pair_base_s = '0;
        run_len_s   = twice_rl_s;
      end else if (next_pair) begin
        pair_base_s = pb_sum_s;
      end else begin
        pair_base_s = pair_base_r;
      end
    end
    rd_off_s = sel_b_nxt ? run_len_s : '0;
  end

  // Counter registers and look-ahead addresses for the following cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pair_base_r <= '0;
      run_len_r   <= CW'(1);
      ld_cnt_r    <= '0;
      wr_cnt_r    <= '0;
      rd_addr_r   <= '0;
      wr_addr_r   <= '0;
    end else begin
      pair_base_r <= pair_base_s;
      run_len_r   <= run_len_s;
      ld_cnt_r    <= ld_cnt_s;
      wr_cnt_r    <= wr_cnt_s;
      rd_addr_r   <= ADDR_W'(pair_base_s + rd_off_s + ld_cnt_s);
      wr_addr_r   <= ADDR_W'(pair_base_s + wr_cnt_s);
    end
  end

  assign rd_addr = rd_addr_r;
  assign wr_addr = wr_addr_r;
`ifdef MERGE_CTRL_TIMEOUT_EN
  assign run_len = run_len_r;
`endif

endmodule

// File: rtl/merge_sort_ctrl.sv
// Pass scheduler for the merge-sort datapath. Streams pairs of sorted runs
// from the source bank into the merge unit's FIFOs, waits for the merged
// words, then doubles the run length and swaps banks until one run remains.
// Optional build macro: MERGE_CTRL_TIMEOUT_EN adds a MERGE watchdog driving err.
module merge_sort_ctrl
  import merge_sort_pkg::*;
#(
  parameter int unsigned WIDTH  = 32'd8,
  parameter int unsigned N      = 32'd8,
  parameter int unsigned ADDR_W = MS_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              push_fifo1,
  output logic              push_fifo2,
  output logic              merge_go,
  input  logic              merge_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [2:0]        pass,
  output logic              err
);

  localparam int unsigned LOG2_N = ms_clog2(N);

  // Elaboration-time sanity of the configuration (no hardware)
  if ((WIDTH < 32'd1) || ((32'd1 << LOG2_N) != N) || (LOG2_N > ADDR_W)) begin : g_param_invalid
  end

  state_t      state_r;
  logic        busy_r, done_r, push1_r, push2_r, go_r, bank_r, wr_bank_r;
  logic [2:0]  pass_r;
  logic        init_s, ld_step_s, sel_b_nxt_s, wr_step_s, next_s;
  logic        ld_last_s, wr_last_s, pass_wrap_s, sort_last_s, wd_expire_s;

  // FSM strobes for the address generator
  always_comb begin
    init_s      = (state_r == IDLE) && start;
    ld_step_s   = (state_r == LOAD_A) || (state_r == LOAD_B);
    wr_step_s   = (state_r == MERGE) && merge_we;
    next_s      = (state_r == NEXT);
    if (state_r == LOAD_A) begin
      sel_b_nxt_s = ld_last_s;
    end else if (state_r == LOAD_B) begin
      sel_b_nxt_s = !ld_last_s;
    end else begin
      sel_b_nxt_s = 1'b0;
    end
  end

`ifdef MERGE_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = ADDR_W + 32'd3;
  logic [ADDR_W:0]   run_len_s;
  logic [WD_W-1:0]   wd_cnt_r, wd_limit_s;
  logic              err_r;

  // Watchdog expiry: MERGE has lasted 4*run_len+8 cycles without finishing
  always_comb begin
    wd_limit_s = {run_len_s, 2'b00} + WD_W'(8);
    if ((state_r == MERGE) && !(merge_we && wr_last_s)) begin
      wd_expire_s = (wd_cnt_r == (wd_limit_s - WD_W'(1)));
    end else begin
      wd_expire_s = 1'b0;
    end
  end

  // MERGE cycle counter and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      wd_cnt_r <= (state_r == MERGE) ? (wd_cnt_r + WD_W'(1)) : '0;
      err_r    <= err_r | wd_expire_s;
    end
  end

  assign err = err_r;
`else
  assign wd_expire_s = 1'b0;
  assign err         = 1'b0;
`endif

  merge_addr_gen #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .init      (init_s),
    .ld_step   (ld_step_s),
    .sel_b_nxt (sel_b_nxt_s),
    .wr_step   (wr_step_s),
    .next_pair (next_s),
`ifdef MERGE_CTRL_TIMEOUT_EN
    .run_len   (run_len_s),
`endif
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .ld_last   (ld_last_s),
    .wr_last   (wr_last_s),
    .pass_wrap (pass_wrap_s),
    .sort_last (sort_last_s)
  );

  // Pass-scheduler FSM; outputs are registered for the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      push1_r   <= 1'b1;
      push2_r   <= 1'b1;
      go_r      <= 1'b0;
      bank_r    <= 1'b0;
      wr_bank_r <= 1'b1;
      pass_r    <= 3'd0;
    end else begin
      done_r  <= 1'b0;
      push1_r <= 1'b1;
      push2_r <= 1'b1;
      go_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= LOAD_A;
            busy_r    <= 1'b1;
            push1_r   <= 1'b0;
            bank_r    <= 1'b0;
            wr_bank_r <= 1'b1;
            pass_r    <= 3'd0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        LOAD_A: begin
          if (ld_last_s) begin
            state_r <= LOAD_B;
            push2_r <= 1'b0;
          end else begin
            state_r <= LOAD_A;
            push1_r <= 1'b0;
          end
        end
        LOAD_B: begin
          if (ld_last_s) begin
            state_r <= MERGE;
            go_r    <= 1'b1;
          end else begin
            state_r <= LOAD_B;
            push2_r <= 1'b0;
          end
        end
        MERGE: begin
          if (wd_expire_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (merge_we && wr_last_s) begin
            state_r <= NEXT;
          end else begin
            state_r <= MERGE;
            go_r    <= 1'b1;
          end
        end
        NEXT: begin
          if (pass_wrap_s) begin
            bank_r    <= !bank_r;
            wr_bank_r <= bank_r;
            pass_r    <= pass_r + 3'd1;
          end else begin
            bank_r    <= bank_r;
            wr_bank_r <= wr_bank_r;
            pass_r    <= pass_r;
          end
          if (sort_last_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= LOAD_A;
            push1_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign push_fifo1 = push1_r;
  assign push_fifo2 = push2_r;
  assign merge_go   = go_r;
  assign rd_bank    = bank_r;
  assign wr_bank    = wr_bank_r;
  assign pass       = pass_r;

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Bench for merge_sort_ctrl (N=8): register-file and merge-unit models around
// the controller, random data sorted by a queue reference.
module tb_merge_sort_ctrl;

  localparam int N      = 8;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              merge_we = 1'b0;
  logic              busy, done, rd_bank, push_fifo1, push_fifo2, merge_go, wr_bank, err;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [2:0]        pass;

  merge_sort_ctrl #(.WIDTH(8), .N(N), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_bank(rd_bank), .push_fifo1(push_fifo1),
    .push_fifo2(push_fifo2), .merge_go(merge_go), .merge_we(merge_we),
    .wr_addr(wr_addr), .wr_bank(wr_bank), .pass(pass), .err(err)
  );

  always #5 clock = ~clock;

  logic [7:0] rf [0:1][0:31];
  logic [7:0] src [0:N-1];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] exp_q [$];
  bit load_req = 1'b0, stall_en = 1'b0, spur_en = 1'b0, mon_clr = 1'b0;
  int n_chk = 0, n_err = 0;
  int busy_cyc, done_cnt, p1_cnt, p2_cnt, win_cnt, first_len;
  int win_pass [0:7];
  logic [ADDR_W-1:0] first1, first2;
  bit prev_go = 1'b0;
  int exp_cyc, exp_pairs, exp_passes;

  // Register file and merge unit: FIFOs fill on active-low pushes, merge pops the smaller head
  always @(posedge clock) begin
    logic [7:0] v;
    if (load_req) for (int i = 0; i < N; i++) rf[0][i] = src[i];
    if (reset) begin
      q1.delete();
      q2.delete();
    end else begin
      if (!push_fifo1) q1.push_back(rf[rd_bank][rd_addr]);
      if (!push_fifo2) q2.push_back(rf[rd_bank][rd_addr]);
      if (merge_we && merge_go) begin
        if (q2.size() == 0 || (q1.size() != 0 && q1[0] <= q2[0])) v = q1.pop_front();
        else v = q2.pop_front();
        rf[wr_bank][wr_addr] = v;
      end
    end
  end

  // Merge write strobe: one word per cycle while enabled, optional noise outside MERGE
  always @(negedge clock) begin
    if (merge_go) merge_we = !stall_en && (q1.size() + q2.size() != 0);
    else if (spur_en) merge_we = ($urandom_range(0, 1) == 1);
    else merge_we = 1'b0;
  end

  // Activity monitor
  always @(negedge clock) begin
    if (mon_clr) begin
      busy_cyc = 0; done_cnt = 0; p1_cnt = 0; p2_cnt = 0; win_cnt = 0; first_len = 0;
      for (int i = 0; i < 8; i++) win_pass[i] = 0;
      first1 = '0; first2 = '0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (!push_fifo1) begin if (p1_cnt == 0) first1 = rd_addr; p1_cnt++; end
      if (!push_fifo2) begin if (p2_cnt == 0) first2 = rd_addr; p2_cnt++; end
      if (merge_go && !prev_go) begin win_cnt++; win_pass[pass]++; end
      if (merge_go && win_cnt == 1) first_len++;
    end
    prev_go = merge_go;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) src[i] = 8'($urandom_range(0, 255));
    exp_q = {};
    for (int i = 0; i < N; i++) exp_q.push_back(src[i]);
    exp_q.sort();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_merge(input logic [2:0] p, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (pass === p && merge_go === 1'b1) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < N; i++) check(tag, 32'(rf[1][i]), 32'(exp_q[i]));
  endtask

  task automatic full_sort(input bit spur, input bit first_detail, input string tag);
    load_random();
    spur_en = spur;
    mon_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done({tag, "_done"});
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_rd_bank"}, 32'(rd_bank), 32'(exp_passes % 2));
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'(1 - exp_passes % 2));
    tick();
    tick();
    spur_en = 1'b0;
    check({tag, "_cycles"}, 32'(busy_cyc), 32'(exp_cyc));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_pairs"}, 32'(win_cnt), 32'(exp_pairs));
    for (int p = 0; p < exp_passes; p++)
      check({tag, "_pairs_in_pass"}, 32'(win_pass[p]), 32'(N >> (p + 1)));
    check({tag, "_push1_cnt"}, 32'(p1_cnt), 32'(N / 2 * exp_passes));
    check({tag, "_push2_cnt"}, 32'(p2_cnt), 32'(N / 2 * exp_passes));
    if (first_detail) begin
      check({tag, "_first_rd_a"}, 32'(first1), 32'd0);
      check({tag, "_first_rd_b"}, 32'(first2), 32'd1);
      check({tag, "_first_merge_len"}, 32'(first_len), 32'd2);
    end
    check_result({tag, "_data"});
  endtask

  initial begin
    exp_cyc = 0; exp_pairs = 0; exp_passes = 0;
    for (int rl = 1; rl < N; rl *= 2) begin
      exp_passes++;
      exp_pairs += N / (2 * rl);
      exp_cyc   += 2 * N + N / (2 * rl);
    end

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_push1", 32'(push_fifo1), 32'd1);
    check("rst_push2", 32'(push_fifo2), 32'd1);
    check("rst_go", 32'(merge_go), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_wr_bank", 32'(wr_bank), 32'd1);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Plain sort with first-pair timing detail, then one with merge_we noise outside MERGE
    full_sort(1'b0, 1'b1, "sort0");
    full_sort(1'b1, 1'b0, "spur");

    // Reset during pass-1 MERGE
    load_random();
    mon_reset();
    start = 1'b1; tick(); start = 1'b0;
    wait_merge(3'd1, "midrst_reach");
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_push1", 32'(push_fifo1), 32'd1);
    check("midrst_push2", 32'(push_fifo2), 32'd1);
    check("midrst_go", 32'(merge_go), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_done_cnt", 32'(done_cnt), 32'd0);

    // start held through a full sort: one sort, next only after IDLE
    load_random();
    mon_reset();
    start = 1'b1;
    wait_done("held_done1");
    check("held_busy_done", 32'(busy), 32'd0);
    tick();
    check("held_busy_idle", 32'(busy), 32'd0);
    check("held_done_cnt1", 32'(done_cnt), 32'd1);
    check("held_cycles1", 32'(busy_cyc), 32'(exp_cyc));
    tick();
    check("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("held_done2");
    tick(); tick();
    check("held_done_cnt2", 32'(done_cnt), 32'd2);
    check("held_cycles2", 32'(busy_cyc), 32'(2 * exp_cyc));
    check_result("held_data");

    // Merge unit stalled at run_len=2
    load_random();
    mon_reset();
    start = 1'b1; tick(); start = 1'b0;
    wait_merge(3'd1, "stall_reach");
    stall_en = 1'b1;
    repeat (15) tick();
    check("stall_go_c16", 32'(merge_go), 32'd1);
    tick();
`ifdef MERGE_CTRL_TIMEOUT_EN
    check("stall_err", 32'(err), 32'd1);
    check("stall_go", 32'(merge_go), 32'd0);
    check("stall_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("stall_err_sticky", 32'(err), 32'd1);
`else
    check("stall_err", 32'(err), 32'd0);
    check("stall_go", 32'(merge_go), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    repeat (20) tick();
    check("stall_go_late", 32'(merge_go), 32'd1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall_en = 1'b0;
    check("stall_err_cleared", 32'(err), 32'd0);
    tick();

    // More random sorts
    for (int k = 0; k < 3; k++) full_sort(k[0], 1'b0, "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/merge_sort_ctrl.md
# merge_sort_ctrl

Pass scheduler for the merge-sort datapath. Sorts N words held in a two-bank register file using one two-FIFO merge unit. Each pass streams pairs of sorted runs from the source bank into the merge unit's input FIFOs, counts the merged words written to the destination bank, then doubles the run length and swaps banks until a single run of N remains.

## Interface
Parameters:
- `WIDTH`, 8, data word width; informational only, no datapath passes through this block.
- `N`, 8, total element count; power of two, 2..32.
- `ADDR_W`, 5, register-file address width; must satisfy 2^ADDR_W ≥ N.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a sort; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` until DONE.
- `done`  out  1  one-cycle pulse when sort completes.
- `rd_addr`  out  ADDR_W  source read address; register file read is combinational.
- `rd_bank`  out  1  source bank select.
- `push_fifo1`, `push_fifo2`  out  1 each  push to merge input FIFOs, active-low.
- `merge_go`  out  1  level, high while in MERGE; enables the merge unit.
- `merge_we`  in  1  merge unit write strobe, active-high.
- `wr_addr`  out  ADDR_W  destination write address (`pair_base` + write count).
- `wr_bank`  out  1  destination bank, always `!rd_bank`.
- `pass`  out  3  current pass index, 0-based.
- `err`  out  1  sticky watchdog error (see Configuration).

## Operation
- Internal registers:
  - `run_len`: power of two, 1..N/2.
  - `pair_base`, `ld_cnt`, `wr_cnt`: ADDR_W+1 bits, so N=32 needs no wrap.
  - `bank`, `pass`.
- States and transitions:
  - IDLE: `start` → LOAD_A. Clear `run_len`=1, `pair_base`=0, `pass`=0, `bank`=0.
  - LOAD_A: `push_fifo1`=0, `rd_addr`=`pair_base`+`ld_cnt`. `ld_cnt`++ each cycle; after `run_len` pushes → LOAD_B, `ld_cnt`=0.
  - LOAD_B: same as LOAD_A on `push_fifo2`, reading `pair_base`+`run_len`+`ld_cnt`. After `run_len` pushes → MERGE.
  - MERGE: `merge_go`=1. Each `merge_we` increments `wr_cnt`. On the strobe where `wr_cnt` reaches 2·`run_len`-1 → NEXT.
  - NEXT, one cycle:
    - `pair_base` += 2·`run_len`, `wr_cnt`=0.
    - If `pair_base` reaches N: `pair_base`=0, `run_len`<<=1, `bank` toggles, `pass`++.
    - If the new `run_len`==N → DONE; else → LOAD_A.
  - DONE: `done`=1 for one cycle → IDLE.
- Outputs by state:
  - `push_*` are high (inactive) outside LOAD_A/LOAD_B.
  - `rd_addr`/`wr_addr` are don't-care outside their active states but held registered, not X.
- Result location: after log2(N) passes; bank = log2(N) mod 2.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `push_fifo1`=`push_fifo2`=1, `merge_go`=0.
  - `rd_addr`=0, `wr_addr`=0, `rd_bank`=0, `wr_bank`=1, `pass`=0, `err`=0.
  - State IDLE.
- `reset` mid-operation: returns to IDLE next edge; no `done` pulse; register-file contents are not restored.
- `start` while busy: ignored.
- `start` and `reset` in the same cycle: reset wins.
- Per pair: 2·`run_len` load cycles + merge time + 1 NEXT cycle.
  - A merge unit that writes every cycle gives 4·`run_len`+1 cycles per pair.
  - The pair count per pass is N/(2·`run_len`), so each pass costs 2N + N/(2·`run_len`) cycles.
- `merge_we` while not in MERGE: ignored, and it does not advance `wr_cnt`.
- Input FIFO depth must be ≥ N/2; this block does not check FIFO full.

## Configuration
- `MERGE_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles in MERGE.
  - If the count exceeds 4·`run_len`+8 without completion: `err` sets (sticky until reset), FSM → IDLE, no `done`.
- Undefined: no watchdog; MERGE waits indefinitely; `err` tied 0.

## Structure
- Package `merge_sort_pkg`:
  - State enum (IDLE, LOAD_A, LOAD_B, MERGE, NEXT, DONE).
  - Address-width constant and a clog2 helper.
  - Shared with the merge unit and register file.
- One sub-module, `merge_addr_gen`:
  - Owns `pair_base`, `run_len`, `ld_cnt`, `wr_cnt`.
  - Produces `rd_addr`/`wr_addr` from FSM strobes.
  - The FSM stays in `merge_sort_ctrl`.

## Test plan
- N=8, `start` pulse, behavioural merge unit writing one word per cycle, data {7,3,6,1,8,2,5,4} → `pass` steps 0,1,2; 7 pairs total; `done` once; bank 1 holds {1,2,3,4,5,6,7,8}.
- Pass 0, first pair → LOAD_A drives `rd_addr`=0 with `push_fifo1`=0 for exactly 1 cycle; LOAD_B drives `rd_addr`=1 with `push_fifo2`=0; MERGE exits after 2 `merge_we`.
- `reset` asserted during pass 1 MERGE → next cycle IDLE, `busy`=0, all pushes 1, `done` never pulses.
- `start` held high through an entire sort → exactly one sort, and a second starts only after returning to IDLE.
- N=32, full sort → `pass` reaches 4; `pair_base` reaches 32 without wrap; result in bank 1.
- With `MERGE_CTRL_TIMEOUT_EN` and the merge unit stalled (no `merge_we`) at `run_len`=2 → `err`=1 after 16 MERGE cycles, FSM in IDLE; without the macro → FSM stays in MERGE and `err`=0.
